// File: rtl/bsg_lru_pkg.sv
// Purpose: shared pseudo-tree-LRU encoding constants and heap node-index helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: LRU_DIR_LEFT/RIGHT bit meaning, lru_left/lru_right child index, lru_level depth of a node.
package bsg_lru_pkg;

  // A tree bit of 0 steers the victim walk towards the lower-numbered ways.
  localparam logic LRU_DIR_LEFT  = 1'b0;
  localparam logic LRU_DIR_RIGHT = 1'b1;

  function automatic int lru_left(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int lru_right(input int n);
    return 2 * n + 2;
  endfunction

  // Depth of node n in the heap (root is level 0), i.e. floor(log2(n+1)).
  function automatic int lru_level(input int n);
    int lvl;
    lvl = 0;
    for (int i = 1; i < 31; i++) begin
      if (((n + 1) >> i) != 0) lvl = i;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/bsg_lru_pseudo_tree_tracker_if.sv
// Purpose: touch / allocate / victim bundle between a cache controller and the LRU tracker.
// Latency: n/a (wires only).
// Backpressure: alloc is valid/ready, victim is valid/yumi, touch is always accepted.
// Modports: master = controller side, slave = tracker side. lock_mask_i exists only with BSG_LRU_TREE_LOCK_EN.
interface bsg_lru_pseudo_tree_tracker_if #(
  parameter int ways_p = 8,
  parameter int sets_p = 64
);
  localparam int lg_ways_lp = $clog2(ways_p);
  localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1;

  logic                  touch_v_i;
  logic [lg_sets_lp-1:0] touch_set_i;
  logic [lg_ways_lp-1:0] touch_way_i;
  logic                  alloc_v_i;
  logic [lg_sets_lp-1:0] alloc_set_i;
  logic                  alloc_ready_o;
  logic                  victim_v_o;
  logic [lg_ways_lp-1:0] victim_way_o;
  logic                  victim_yumi_i;
`ifdef BSG_LRU_TREE_LOCK_EN
  logic [ways_p-1:0]     lock_mask_i;
`endif

  modport master (
`ifdef BSG_LRU_TREE_LOCK_EN
    output lock_mask_i,
`endif
    output touch_v_i, touch_set_i, touch_way_i,
    output alloc_v_i, alloc_set_i, victim_yumi_i,
    input  alloc_ready_o, victim_v_o, victim_way_o
  );

  modport slave (
`ifdef BSG_LRU_TREE_LOCK_EN
    input  lock_mask_i,
`endif
    input  touch_v_i, touch_set_i, touch_way_i,
    input  alloc_v_i, alloc_set_i, victim_yumi_i,
    output alloc_ready_o, victim_v_o, victim_way_o
  );

endinterface

// File: rtl/bsg_lru_pseudo_tree_encode.sv
// Purpose: walks one set's pseudo-LRU tree from the root to a victim way.
// Latency: combinational.
// Backpressure: none.
// Ports: tree_i (ways_p-1 tree bits), lock_mask_i (only with BSG_LRU_TREE_LOCK_EN), way_o (victim way).
module bsg_lru_pseudo_tree_encode
  import bsg_lru_pkg::*;
#(
  parameter  int ways_p     = 8,
  localparam int lg_ways_lp = $clog2(ways_p)
) (
`ifdef BSG_LRU_TREE_LOCK_EN
  input  logic [ways_p-1:0]     lock_mask_i,
`endif
  input  logic [ways_p-2:0]     tree_i,
  output logic [lg_ways_lp-1:0] way_o
);

  logic [ways_p-1:0] lock_eff;

`ifdef BSG_LRU_TREE_LOCK_EN
  // With every way locked there is nothing to steer towards, so fall back to the plain tree.
  assign lock_eff = (&lock_mask_i) ? '0 : lock_mask_i;
`else
  assign lock_eff = '0;
`endif

  function automatic logic [lg_ways_lp-1:0] walk(input logic [ways_p-2:0] tree,
                                                 input logic [ways_p-1:0] lock);
    int                node;
    int                prefix;
    int                sz;
    logic              dir;
    logic [ways_p-2:0] tsh;
    logic [ways_p-1:0] sub;
    logic [ways_p-1:0] ones;
    node   = 0;
    prefix = 0;
    ones   = '1;
    for (int l = 0; l < lg_ways_lp; l++) begin
      tsh = tree >> node;
      dir = tsh[0];
      // sz = number of ways under each child of this node.
      sz  = ways_p >> (lru_level(node) + 1);
      sub = lock >> (((prefix << 1) | int'(dir)) * sz);
      // Pointed subtree fully locked: the sibling must hold an unlocked way.
      if ((sub | (ones << sz)) == ones) dir = ~dir;
      prefix = (prefix << 1) | int'(dir);
      node   = (dir == LRU_DIR_LEFT) ? lru_left(node) : lru_right(node);
    end
    return lg_ways_lp'(prefix);
  endfunction

  assign way_o = walk(tree_i, lock_eff);

endmodule

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Purpose: per-set pseudo-tree-LRU state with hit touches and a registered victim allocator.
// Latency: victim_v_o one cycle after alloc accept; touches and yumi auto-touch take effect next cycle.
// Backpressure: alloc_ready_o high in IDLE, else only in the yumi cycle; victim held until yumi.
// Ports: clk_i, reset_n_i (async active-low), bus (slave modport: touch, alloc, victim, optional lock).
// Optional: BSG_LRU_TREE_LOCK_EN adds lock_mask_i, sampled at accept, steering the walk off locked ways.
module bsg_lru_pseudo_tree_tracker
  import bsg_lru_pkg::*;
#(
  parameter  int ways_p     = 8,
  parameter  int sets_p     = 64,
  localparam int lg_ways_lp = $clog2(ways_p),
  localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_lru_pseudo_tree_tracker_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [lg_sets_lp-1:0] set_q, set_d;
  logic                  set_ok_q, set_ok_d;
  logic [lg_ways_lp-1:0] victim_way_q, victim_way_d;
  logic [ways_p-2:0]     tree_q [sets_p];
  logic [ways_p-2:0]     tree_d [sets_p];

  logic                  touch_ok, alloc_ok, yumi, accept;
  logic [ways_p-2:0]     t_mask, t_data, v_mask, v_data;
  logic [ways_p-2:0]     alloc_tree;
  logic [lg_ways_lp-1:0] enc_way;

  function automatic logic set_in_range(input logic [lg_sets_lp-1:0] s);
    return (sets_p == 1) || (32'(s) < 32'(sets_p));
  endfunction

  // Single-set configurations ignore the set index entirely.
  function automatic logic [lg_sets_lp-1:0] set_idx(input logic [lg_sets_lp-1:0] s);
    return (sets_p == 1) ? '0 : s;
  endfunction

  // Nodes on the path to `way`, each written to point away from it.
  function automatic void path_bits(input  logic [lg_ways_lp-1:0] way,
                                    output logic [ways_p-2:0]     mask,
                                    output logic [ways_p-2:0]     data);
    int                    node;
    logic [lg_ways_lp-1:0] wsh;
    logic [ways_p-2:0]     one;
    node = 0;
    mask = '0;
    data = '0;
    one  = '0;
    one[0] = 1'b1;
    for (int l = 0; l < lg_ways_lp; l++) begin
      wsh  = way >> (lg_ways_lp - 1 - l);
      mask = mask | (one << node);
      if (wsh[0] == LRU_DIR_LEFT) data = data | (one << node);
      node = (wsh[0] == LRU_DIR_LEFT) ? lru_left(node) : lru_right(node);
    end
  endfunction

  assign bus.alloc_ready_o = (state_q == ST_IDLE) || bus.victim_yumi_i;
  assign bus.victim_v_o    = (state_q == ST_HOLD);
  assign bus.victim_way_o  = victim_way_q;

  assign accept   = bus.alloc_v_i && bus.alloc_ready_o;
  assign yumi     = bus.victim_yumi_i && (state_q == ST_HOLD);
  assign touch_ok = bus.touch_v_i && set_in_range(bus.touch_set_i);
  assign alloc_ok = set_in_range(bus.alloc_set_i);

  always_comb begin
    path_bits(bus.touch_way_i, t_mask, t_data);
    path_bits(victim_way_q, v_mask, v_data);
  end

  // Hit touch first, then the victim auto-touch, so the victim wins on shared nodes.
  always_comb begin
    for (int s = 0; s < sets_p; s++) begin
      tree_d[s] = tree_q[s];
      if (touch_ok && (set_idx(bus.touch_set_i) == lg_sets_lp'(s)))
        tree_d[s] = (tree_d[s] & ~t_mask) | (t_data & t_mask);
      if (yumi && set_ok_q && (set_q == lg_sets_lp'(s)))
        tree_d[s] = (tree_d[s] & ~v_mask) | (v_data & v_mask);
    end
  end

  // The walk reads the already-updated tree so same-cycle touches/yumi are seen.
  assign alloc_tree = alloc_ok ? tree_d[set_idx(bus.alloc_set_i)] : '0;

  bsg_lru_pseudo_tree_encode #(.ways_p(ways_p)) encode (
`ifdef BSG_LRU_TREE_LOCK_EN
    .lock_mask_i (bus.lock_mask_i),
`endif
    .tree_i      (alloc_tree),
    .way_o       (enc_way)
  );

  always_comb begin
    state_d      = state_q;
    set_d        = set_q;
    set_ok_d     = set_ok_q;
    victim_way_d = victim_way_q;
    if (accept) begin
      state_d      = ST_HOLD;
      set_d        = set_idx(bus.alloc_set_i);
      set_ok_d     = alloc_ok;
      victim_way_d = alloc_ok ? enc_way : '0;
    end else if (yumi) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      set_q        <= '0;
      set_ok_q     <= 1'b0;
      victim_way_q <= '0;
      for (int s = 0; s < sets_p; s++) tree_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      set_ok_q     <= set_ok_d;
      victim_way_q <= victim_way_d;
      for (int s = 0; s < sets_p; s++) tree_q[s] <= tree_d[s];
    end
  end

endmodule
